// File: rtl/mypack.sv
`default_nettype none
// mypack: shared state, register-select and micro-sequencing types for rv_mcycle_ctrl.
// Rev 1.0
package mypack;

  typedef enum logic [4:0] {
    ST_INIT = 5'd0,
    ST_F0   = 5'd1,  ST_F1   = 5'd2,  ST_F2   = 5'd3,
    ST_A0   = 5'd4,  ST_A1   = 5'd5,  ST_A2   = 5'd6,  ST_A3   = 5'd7,
    ST_AI0  = 5'd8,  ST_AI1  = 5'd9,  ST_AI2  = 5'd10, ST_AI3  = 5'd11,
    ST_LW0  = 5'd12, ST_LW1  = 5'd13, ST_LW2  = 5'd14, ST_LW3  = 5'd15,
    ST_SW0  = 5'd16, ST_SW1  = 5'd17, ST_SW2  = 5'd18, ST_SW3  = 5'd19,
    ST_JR0  = 5'd20, ST_JR1  = 5'd21, ST_JR2  = 5'd22, ST_JR3  = 5'd23
  } uState;

  typedef enum logic [1:0] {UOP_N = 2'd0, UOP_B = 2'd1, UOP_D = 2'd2, UOP_F = 2'd3} uinst;

  typedef enum logic [1:0] {RF_X0 = 2'd0, RF_RS1 = 2'd1, RF_RS2 = 2'd2, RF_RD = 2'd3} RF_reg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    uinst  uop;
    RF_reg rf_sel;
    logic  rf_we;
    logic  ir_we;
    logic  pc_we;
    logic  alu_we;
    logic  pc_src;
    logic  alu_imm;
    logic  alu_add;
    logic  mem_req;
    logic  mem_we;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/rv_mcycle_ctrl_if.sv
`default_nettype none
// rv_mcycle_ctrl_if: controller <-> datapath/memory signal bundle.
// Rev 1.0
interface rv_mcycle_ctrl_if;
  import mypack::*;

  logic [31:0] instr;
  logic        mem_rdy;
  logic        stall;
  uState       state;
  uinst        uop;
  RF_reg       rf_sel;
  logic        rf_we;
  logic        ir_we;
  logic        pc_we;
  logic        alu_we;
  logic        pc_src;
  logic        alu_imm;
  logic        alu_add;
  logic        mem_req;
  logic        mem_we;
  logic        illegal;
  logic        timeout;
  logic        retire;

  modport master (
    input  instr, mem_rdy, stall,
    output state, uop, rf_sel, rf_we, ir_we, pc_we, alu_we, pc_src,
           alu_imm, alu_add, mem_req, mem_we, illegal, timeout, retire
  );

  modport slave (
    output instr, mem_rdy, stall,
    input  state, uop, rf_sel, rf_we, ir_we, pc_we, alu_we, pc_src,
           alu_imm, alu_add, mem_req, mem_we, illegal, timeout, retire
  );

endinterface
`default_nettype wire

// File: rtl/rv_ctrl_decode.sv
`default_nettype none
// rv_ctrl_decode: pure Moore decode of the control state into datapath strobes.
// Rev 1.0
module rv_ctrl_decode
  import mypack::*;
(
  input  uState state,
  output ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_F0:  begin ctrl.mem_req = 1'b1; ctrl.uop = UOP_B; end
      ST_F1:  ctrl.ir_we = 1'b1;
      ST_F2:  begin ctrl.pc_we = 1'b1; ctrl.rf_sel = RF_RS1; ctrl.uop = UOP_D; end
      ST_A0:  ctrl.rf_sel = RF_RS1;
      ST_A1:  ctrl.rf_sel = RF_RS2;
      ST_A2:  ctrl.alu_we = 1'b1;
      ST_A3:  begin ctrl.rf_sel = RF_RD; ctrl.rf_we = 1'b1; ctrl.uop = UOP_F; end
      ST_AI0: ctrl.rf_sel = RF_RS1;
      ST_AI2: begin ctrl.alu_we = 1'b1; ctrl.alu_imm = 1'b1; end
      ST_AI3: begin ctrl.rf_sel = RF_RD; ctrl.rf_we = 1'b1; ctrl.uop = UOP_F; end
      ST_LW0: ctrl.rf_sel = RF_RS1;
      ST_LW1: begin ctrl.alu_we = 1'b1; ctrl.alu_imm = 1'b1; ctrl.alu_add = 1'b1; end
      ST_LW2: begin ctrl.mem_req = 1'b1; ctrl.uop = UOP_B; end
      ST_LW3: begin ctrl.rf_sel = RF_RD; ctrl.rf_we = 1'b1; ctrl.uop = UOP_F; end
      ST_SW0: ctrl.rf_sel = RF_RS1;
      ST_SW1: begin ctrl.alu_we = 1'b1; ctrl.alu_imm = 1'b1; ctrl.alu_add = 1'b1; end
      ST_SW2: ctrl.rf_sel = RF_RS2;
      // Stays a bus-wait class while held; completion is seen as retire on the next cycle.
      ST_SW3: begin ctrl.mem_req = 1'b1; ctrl.mem_we = 1'b1; ctrl.uop = UOP_B; end
      ST_JR0: ctrl.rf_sel = RF_RS1;
      ST_JR1: begin ctrl.alu_we = 1'b1; ctrl.alu_imm = 1'b1; ctrl.alu_add = 1'b1; end
      ST_JR2: begin ctrl.rf_sel = RF_RD; ctrl.rf_we = 1'b1; end
      ST_JR3: begin ctrl.pc_we = 1'b1; ctrl.pc_src = 1'b1; ctrl.uop = UOP_F; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_mcycle_ctrl.sv
`default_nettype none
// rv_mcycle_ctrl: multi-cycle RV32 subset control FSM with memory-wait timeout.
// Rev 1.0
module rv_mcycle_ctrl
  import mypack::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  rv_mcycle_ctrl_if.master     bus
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  uState       cur_state;
  uState       nxt_state;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nxt;
  logic [15:0] wait_inc;
  logic        illegal_p, illegal_nxt;
  logic        timeout_p, timeout_nxt;
  logic        retire_p,  retire_nxt;
  logic        rd_zero;
  logic        unused_instr;
  ctrl_t       dec;

  assign wait_inc     = wait_cnt + 16'd1;
  assign rd_zero      = (bus.instr[11:7] == 5'd0);
  assign unused_instr = ^bus.instr[31:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_INIT;
      wait_cnt  <= '0;
      illegal_p <= 1'b0;
      timeout_p <= 1'b0;
      retire_p  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_cnt_nxt;
      illegal_p <= illegal_nxt;
      timeout_p <= timeout_nxt;
      retire_p  <= retire_nxt;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    wait_cnt_nxt = wait_cnt;
    illegal_nxt  = 1'b0;
    timeout_nxt  = 1'b0;
    retire_nxt   = 1'b0;
    if (!bus.stall) begin
      case (cur_state)
        ST_INIT: nxt_state = ST_F0;
        // Bus-wait states: completion beats the timeout when both land together.
        ST_F0, ST_LW2, ST_SW3: begin
          if (bus.mem_rdy) begin
            if (cur_state == ST_F0) begin
              nxt_state = ST_F1;
            end else if (cur_state == ST_LW2) begin
              nxt_state = ST_LW3;
            end else begin
              nxt_state  = ST_F0;
              retire_nxt = 1'b1;
            end
          end else begin
            wait_cnt_nxt = wait_inc;
            if (wait_inc == TIMEOUT_CNT) begin
              nxt_state   = ST_INIT;
              timeout_nxt = 1'b1;
            end
          end
        end
        ST_F1: nxt_state = ST_F2;
        ST_F2: begin
          case (bus.instr[6:0])
            OP_R:    nxt_state = ST_A0;
            OP_I:    nxt_state = ST_AI0;
            OP_LW:   nxt_state = ST_LW0;
            OP_SW:   nxt_state = ST_SW0;
            OP_JALR: nxt_state = ST_JR0;
            default: begin
              nxt_state   = ST_F0;
              illegal_nxt = 1'b1;
            end
          endcase
        end
        ST_A0:  nxt_state = ST_A1;
        ST_A1:  nxt_state = ST_A2;
        ST_A2:  nxt_state = ST_A3;
        ST_AI0: nxt_state = ST_AI1;
        ST_AI1: nxt_state = ST_AI2;
        ST_AI2: nxt_state = ST_AI3;
        ST_LW0: nxt_state = ST_LW1;
        ST_LW1: nxt_state = ST_LW2;
        ST_SW0: nxt_state = ST_SW1;
        ST_SW1: nxt_state = ST_SW2;
        ST_SW2: nxt_state = ST_SW3;
        ST_JR0: nxt_state = ST_JR1;
        ST_JR1: nxt_state = ST_JR2;
        ST_JR2: nxt_state = ST_JR3;
        ST_A3, ST_AI3, ST_LW3, ST_JR3: begin
          nxt_state  = ST_F0;
          retire_nxt = 1'b1;
        end
        default: nxt_state = ST_INIT;
      endcase
      if ((nxt_state != cur_state) &&
          ((nxt_state == ST_F0) || (nxt_state == ST_LW2) || (nxt_state == ST_SW3))) begin
        wait_cnt_nxt = '0;
      end
    end
  end

  rv_ctrl_decode u_decode (
    .state (cur_state),
    .ctrl  (dec)
  );

  always_comb begin
    bus.uop     = dec.uop;
    bus.rf_sel  = dec.rf_sel;
    bus.rf_we   = dec.rf_we & ~rd_zero;
    bus.ir_we   = dec.ir_we;
    bus.pc_we   = dec.pc_we;
    bus.alu_we  = dec.alu_we;
    bus.pc_src  = dec.pc_src;
    bus.alu_imm = dec.alu_imm;
    bus.alu_add = dec.alu_add;
    bus.mem_req = dec.mem_req;
    bus.mem_we  = dec.mem_we;
    if (dec.rf_we && rd_zero) begin
      bus.rf_sel = RF_X0;
    end
    // A pending memory request stays visible through a stall; write strobes do not.
    if (bus.stall) begin
      bus.rf_we  = 1'b0;
      bus.ir_we  = 1'b0;
      bus.pc_we  = 1'b0;
      bus.alu_we = 1'b0;
    end
  end

  assign bus.state   = cur_state;
  assign bus.illegal = illegal_p;
  assign bus.timeout = timeout_p;
  assign bus.retire  = retire_p;

endmodule
`default_nettype wire
